// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and its output/skid buffer:
// FSM state encodings, the exception entry address, the PC step and the
// buffered instruction entry type.
package fetch_sequencer_pkg;

  // Sequencer state encodings, kept as plain constants for legacy tools
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  // Address the PC is steered to when an exception is taken
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h00004180;

  // Byte distance between consecutive instructions
  localparam logic [31:0] PC_STEP = 32'd4;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetchEntryT;

  // Exceptions take priority over branch/jump redirects in the same cycle
  function automatic logic [31:0] selectFlushTarget(
    input logic        excRequest,
    input logic [31:0] redirectAddr,
    input logic [31:0] excVector
  );
    return excRequest ? excVector : redirectAddr;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry instruction buffer toward decode: an output register that
// decode sees, backed by a single skid register that catches the word
// returned by memory in the cycle decode first stalls.
module fetch_skid_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] pushWord,
  input  logic [31:0] pushPc,
  input  logic        pop,
  input  logic        flush,
  output logic        valid,
  output logic        full,
  output logic [31:0] outWord,
  output logic [31:0] outPc
);

  fetchEntryT pushEntry;
  fetchEntryT outEntry;
  fetchEntryT skidEntry;
  logic       outValid;
  logic       skidValid;

  // Bundle the incoming word with its address
  always_comb begin
    pushEntry      = '0;
    pushEntry.word = pushWord;
    pushEntry.pc   = pushPc;
  end

  // Occupancy and data movement: a flush drops both entries; a pop
  // refills the output from the skid entry first, otherwise from the
  // incoming push; a push without a pop lands in the first free slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
      outEntry  <= '0;
      skidEntry <= '0;
    end else if (flush) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
    end else if (pop && skidValid) begin
      outEntry  <= skidEntry;
      skidValid <= push;
      if (push) begin
        skidEntry <= pushEntry;
      end
    end else if (pop) begin
      outValid <= push;
      if (push) begin
        outEntry <= pushEntry;
      end
    end else if (push) begin
      if (!outValid) begin
        outEntry <= pushEntry;
        outValid <= 1'b1;
      end else if (!skidValid) begin
        skidEntry <= pushEntry;
        skidValid <= 1'b1;
      end
    end
  end

  // Expose the output entry toward decode and the skid occupancy
  always_comb begin
    valid   = outValid;
    full    = skidValid;
    outWord = outEntry.word;
    outPc   = outEntry.pc;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steers the external PC register (hold / jump / target),
// issues one instruction-memory request per PC value and hands fetched
// words to decode through a two-entry buffer. Redirects and exceptions
// flush buffered words and steer the PC; a flush that arrives while a
// request is still outstanding is remembered and applied when memory
// finally acknowledges, so the PC never moves under a live request.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pcValue,
  output logic        pcHold,
  output logic        pcJumpEnabled,
  output logic [31:0] pcJumpTarget,
  output logic        imemReq,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        decodeStall,
  output logic        instValid,
  output logic [31:0] instWord,
  output logic [31:0] instPc,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  input  logic        excValid
);

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic        pendingValid;
  logic [31:0] pendingTarget;
  logic        pendingSet;
  logic        pendingClear;
  logic        flush;
  logic [31:0] flushAddr;
  logic        bufPush;
  logic        bufPop;
  logic        bufFlush;
  logic        bufFull;

  // Merge the two flush sources; the exception vector wins a tie
  always_comb begin
    flush     = excValid | redirectValid;
    flushAddr = selectFlushTarget(excValid, redirectTarget, EXC_VECTOR);
  end

  // Decode takes the presented word whenever it is valid and not stalled
  always_comb begin
    bufPop = instValid & ~decodeStall;
  end

  // Sequencer decisions: request/PC control outputs, buffer commands,
  // pending-jump bookkeeping and the next state
  always_comb begin
    stateNext     = state;
    imemReq       = 1'b0;
    pcHold        = 1'b1;
    pcJumpEnabled = 1'b0;
    pcJumpTarget  = 32'h0;
    bufPush       = 1'b0;
    bufFlush      = 1'b0;
    pendingSet    = 1'b0;
    pendingClear  = 1'b0;

    case (state)
      IDLE: begin
        stateNext = FETCH;
        if (flush) begin
          bufFlush      = 1'b1;
          pcHold        = 1'b0;
          pcJumpEnabled = 1'b1;
          pcJumpTarget  = flushAddr;
        end
      end

      FETCH: begin
        imemReq = 1'b1;
        if (imemAck) begin
          pcHold       = 1'b0;
          pendingClear = 1'b1;
          if (flush) begin
            bufFlush      = 1'b1;
            pcJumpEnabled = 1'b1;
            pcJumpTarget  = flushAddr;
          end else if (pendingValid) begin
            pcJumpEnabled = 1'b1;
            pcJumpTarget  = pendingTarget;
          end else begin
            bufPush = 1'b1;
            if (instValid && decodeStall) begin
              stateNext = HOLD;
            end
          end
        end else if (flush) begin
          bufFlush   = 1'b1;
          pendingSet = 1'b1;
        end
      end

      HOLD: begin
        if (flush) begin
          bufFlush      = 1'b1;
          pcHold        = 1'b0;
          pcJumpEnabled = 1'b1;
          pcJumpTarget  = flushAddr;
          stateNext     = FETCH;
        end else if (!decodeStall || !bufFull) begin
          stateNext = FETCH;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Remember a flush that arrived under an outstanding request; a later
  // flush before the ack simply replaces the remembered target
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pendingValid  <= 1'b0;
      pendingTarget <= 32'h0;
    end else if (pendingSet) begin
      pendingValid  <= 1'b1;
      pendingTarget <= flushAddr;
    end else if (pendingClear) begin
      pendingValid  <= 1'b0;
    end
  end

  fetch_skid_buffer skidBuffer (
    .clock    (clock),
    .reset    (reset),
    .push     (bufPush),
    .pushWord (imemData),
    .pushPc   (pcValue),
    .pop      (bufPop),
    .flush    (bufFlush),
    .valid    (instValid),
    .full     (bufFull),
    .outWord  (instWord),
    .outPc    (instPc)
  );

endmodule
